// File: rtl/axis_pkt_gen_pkg.sv
// Shared types, LFSR constants and payload helpers for the AXI-stream packet generator.
// Used by axis_lfsr_throttle and axis_pkt_gen.
package axis_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } gen_state_e;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'h0001;

  // Widest payload exp_data can build; callers size-cast down to DSIZE (<= EXP_DW)
  localparam int unsigned EXP_DW = 128;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [EXP_DW-1:0] exp_data(input logic [EXP_DW-1:0] pkt,
                                                 input logic [EXP_DW-1:0] beat,
                                                 input int unsigned       half);
    logic [EXP_DW-1:0] mask;
    mask = (EXP_DW'(1) << half) - EXP_DW'(1);
    return (pkt << half) | (beat & mask);
  endfunction

endpackage

// File: rtl/axis_lfsr_throttle.sv
// 16-bit Galois LFSR producing a pseudo-random "hit" with probability min(thr,128)/128.
// Reloaded from seed on load (zero seed replaced by the default), advanced while en is high.
module axis_lfsr_throttle
  import axis_gen_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  input  logic [7:0]  thr,
  output logic        hit
);

  logic [15:0] lfsr;

  // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lfsr <= LFSR_SEED_DEF;
    end else if (load) begin
      lfsr <= (seed == 16'h0000) ? LFSR_SEED_DEF : seed;
    end else if (en) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // lfsr[6:0] never exceeds 127, so any thr >= 128 saturates to "always"
  assign hit = {1'b0, lfsr[6:0]} < thr;

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-stream packet generator: cfg_num packets of cfg_len beats, LFSR-throttled tvalid,
// round-robin tdest. Define AXIS_PKT_GEN_CHECK_EN to add the matching sink/checker.
module axis_pkt_gen
  import axis_gen_pkg::*;
#(
  parameter  int DSIZE = 16,
  parameter  int NCH   = 4,
  parameter  int LEN_W = 16,
  parameter  int NUM_W = 16,
  localparam int TDW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [NUM_W-1:0] cfg_num,
  input  logic [7:0]       cfg_thr,
  input  logic [15:0]      cfg_seed,
  output logic [DSIZE-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [TDW-1:0]   m_axis_tdest,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] sent_pkts
`ifdef AXIS_PKT_GEN_CHECK_EN
  ,
  input  logic [DSIZE-1:0] s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  input  logic [TDW-1:0]   s_axis_tdest,
  input  logic [7:0]       chk_thr,
  output logic [15:0]      chk_err,
  output logic [NUM_W-1:0] chk_pkts
`endif
);

  localparam int unsigned HALF = DSIZE / 2;

  gen_state_e       state, state_n;
  logic [LEN_W-1:0] len_q;
  logic [NUM_W-1:0] num_q;
  logic [7:0]       thr_q;

  // Position of the next beat to be issued; the output registers hold the current one
  logic [LEN_W-1:0] nxt_beat;
  logic [NUM_W-1:0] nxt_pkt;
  logic [TDW-1:0]   nxt_dest;

  logic start_ok, hs, last_hs, final_pkt, at_boundary, stop, can_issue, issue, hit;

  axis_lfsr_throttle u_vld_thr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (start_ok),
    .seed    (cfg_seed),
    .en      (state == SEND),
    .thr     (thr_q),
    .hit     (hit)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    start_ok    = (state == IDLE) && start && (cfg_len != '0) && (cfg_num != '0);
    hs          = m_axis_tvalid && m_axis_tready;
    last_hs     = hs && m_axis_tlast;
    final_pkt   = last_hs && (sent_pkts == num_q - NUM_W'(1));
    // A boundary is either "no beat of a packet in flight" or the closing tlast handshake
    at_boundary = (!m_axis_tvalid && (nxt_beat == '0)) || last_hs;
    stop        = final_pkt || (abort && at_boundary);
    can_issue   = !m_axis_tvalid || m_axis_tready;
    issue       = hit && (nxt_pkt != num_q);

    state_n = state;
    case (state)
      IDLE:    if (start_ok) state_n = SEND;
      SEND:    if (stop) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n != IDLE);
      done  <= (state_n == DONE);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      len_q         <= '0;
      num_q         <= '0;
      thr_q         <= '0;
      nxt_beat      <= '0;
      nxt_pkt       <= '0;
      nxt_dest      <= '0;
      sent_pkts     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdest  <= '0;
    end else if (start_ok) begin
      len_q         <= cfg_len;
      num_q         <= cfg_num;
      thr_q         <= cfg_thr;
      nxt_beat      <= '0;
      nxt_pkt       <= '0;
      nxt_dest      <= '0;
      sent_pkts     <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (state == SEND) begin
      if (last_hs) sent_pkts <= sent_pkts + NUM_W'(1);
      if (stop) begin
        m_axis_tvalid <= 1'b0;
      end else if (can_issue) begin
        m_axis_tvalid <= issue;
        if (issue) begin
          m_axis_tdata <= DSIZE'(exp_data(EXP_DW'(nxt_pkt), EXP_DW'(nxt_beat), HALF));
          m_axis_tlast <= (nxt_beat == len_q - LEN_W'(1));
          m_axis_tdest <= nxt_dest;
          if (nxt_beat == len_q - LEN_W'(1)) begin
            nxt_beat <= '0;
            nxt_pkt  <= nxt_pkt + NUM_W'(1);
            nxt_dest <= (nxt_dest == TDW'(NCH - 1)) ? '0 : nxt_dest + TDW'(1);
          end else begin
            nxt_beat <= nxt_beat + LEN_W'(1);
          end
        end
      end
    end
  end

`ifdef AXIS_PKT_GEN_CHECK_EN
  // Sink side: chk_pkts doubles as the expected packet index
  logic [LEN_W-1:0] chk_beat;
  logic [TDW-1:0]   chk_dest;
  logic             s_hs, s_bad;

  axis_lfsr_throttle u_rdy_thr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (start_ok),
    .seed    (~cfg_seed),
    .en      (1'b1),
    .thr     (chk_thr),
    .hit     (s_axis_tready)
  );

  always_comb begin
    s_hs  = s_axis_tvalid && s_axis_tready;
    s_bad = (s_axis_tdata != DSIZE'(exp_data(EXP_DW'(chk_pkts), EXP_DW'(chk_beat), HALF)))
         || (s_axis_tlast != (chk_beat == len_q - LEN_W'(1)))
         || (s_axis_tdest != chk_dest);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      chk_err  <= '0;
      chk_pkts <= '0;
      chk_beat <= '0;
      chk_dest <= '0;
    end else if (start_ok) begin
      chk_err  <= '0;
      chk_pkts <= '0;
      chk_beat <= '0;
      chk_dest <= '0;
    end else if (s_hs) begin
      if (s_bad && (chk_err != 16'hFFFF)) chk_err <= chk_err + 16'd1;
      // The received tlast, not the model's, realigns the expected position
      if (s_axis_tlast) begin
        chk_beat <= '0;
        chk_pkts <= chk_pkts + NUM_W'(1);
        chk_dest <= (chk_dest == TDW'(NCH - 1)) ? '0 : chk_dest + TDW'(1);
      end else begin
        chk_beat <= chk_beat + LEN_W'(1);
      end
    end
  end
`endif

endmodule
